// File: rtl/axis_burst_packetizer.sv
// rtl/axis_burst_packetizer.sv - AXIS stage that closes packets on input tlast, beat limit or idle timeout
module axis_burst_packetizer #(
    parameter int AXIS_TDATA_WIDTH = 64,
    parameter int AXIS_TKEEP_WIDTH = AXIS_TDATA_WIDTH / 8,
    parameter int AXIS_TUSER_WIDTH = 4,
    parameter int MAX_BEATS        = 256,
    parameter int TIMEOUT_CYCLES   = 64
) (
    input  logic                        axis_clk,
    input  logic                        axis_rst,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [AXIS_TKEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic                        s_axis_tlast,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [AXIS_TKEEP_WIDTH-1:0] m_axis_tkeep,
    output logic [AXIS_TUSER_WIDTH-1:0] m_axis_tuser,
    output logic                        m_axis_tlast,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        flush_pulse
);
    localparam int BCW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int ICW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [BCW-1:0] BEAT_LAST = BCW'(MAX_BEATS - 1);
    localparam logic [ICW-1:0] IDLE_MAX  = ICW'(TIMEOUT_CYCLES);

    logic [AXIS_TDATA_WIDTH-1:0] h_data;
    logic [AXIS_TKEEP_WIDTH-1:0] h_keep;
    logic [AXIS_TUSER_WIDTH-1:0] h_user;
    logic                        h_valid;
    logic                        h_last;
    logic [BCW-1:0]              beat_cnt;
    logic [ICW-1:0]              idle_cnt;

    logic o_free, limit, timeout, h_move, in_hs, out_last;

    assign o_free        = !m_axis_tvalid || m_axis_tready;
    assign limit         = (beat_cnt == BEAT_LAST);
    assign timeout       = (TIMEOUT_CYCLES != 0) && (idle_cnt == IDLE_MAX);
    // The held beat may only leave once we know whether it closes the packet:
    // a successor exists, or one of the closing conditions already applies.
    assign h_move        = h_valid && o_free && (s_axis_tvalid || h_last || limit || timeout);
    assign s_axis_tready = !axis_rst && (!h_valid || h_move);
    assign in_hs         = s_axis_tvalid && s_axis_tready;
    assign out_last      = h_last || limit || timeout;

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            h_valid       <= 1'b0;
            h_last        <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            flush_pulse   <= 1'b0;
            beat_cnt      <= '0;
            idle_cnt      <= '0;
        end else begin
            flush_pulse <= 1'b0;
            if (h_move) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= out_last;
                beat_cnt      <= out_last ? '0 : beat_cnt + 1'b1;
                flush_pulse   <= timeout && !h_last && !limit;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            if (in_hs) begin
                h_valid <= 1'b1;
                h_last  <= s_axis_tlast;
            end else if (h_move) begin
                h_valid <= 1'b0;
            end

            // Keeps counting under backpressure so the timeout stays asserted until the move.
            if (in_hs || !h_valid) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_MAX) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge axis_clk) begin
        if (in_hs) begin
            h_data <= s_axis_tdata;
            h_keep <= s_axis_tkeep;
            h_user <= s_axis_tuser;
        end
        if (h_move) begin
            m_axis_tdata <= h_data;
            m_axis_tkeep <= h_keep;
            m_axis_tuser <= h_user;
        end
    end
endmodule

// File: tb/tb_axis_burst_packetizer.sv
// tb/tb_axis_burst_packetizer.sv - self-checking bench for axis_burst_packetizer
module tb_axis_burst_packetizer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] s_tdata = '0;
    logic [7:0]  s_tkeep = '0;
    logic [3:0]  s_tuser = '0;
    logic        s_tlast = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        m_tready = 1'b1;
    logic        rand_mode = 1'b0;
    logic        sel = 1'b0;

    logic [63:0] a_tdata, b_tdata, c_tdata;
    logic [7:0]  a_tkeep, b_tkeep, c_tkeep;
    logic [3:0]  a_tuser, b_tuser, c_tuser;
    logic        a_tlast, b_tlast, c_tlast;
    logic        a_tvalid, b_tvalid, c_tvalid;
    logic        a_tready, b_tready, c_tready;
    logic        a_flush, b_flush, c_flush;

    always #5 clk = ~clk;

    axis_burst_packetizer #(.MAX_BEATS(4), .TIMEOUT_CYCLES(8)) dut_a (
        .axis_clk(clk), .axis_rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
        .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid), .s_axis_tready(a_tready),
        .m_axis_tdata(a_tdata), .m_axis_tkeep(a_tkeep), .m_axis_tuser(a_tuser),
        .m_axis_tlast(a_tlast), .m_axis_tvalid(a_tvalid), .m_axis_tready(m_tready),
        .flush_pulse(a_flush));

    axis_burst_packetizer #(.MAX_BEATS(4), .TIMEOUT_CYCLES(0)) dut_b (
        .axis_clk(clk), .axis_rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
        .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid), .s_axis_tready(b_tready),
        .m_axis_tdata(b_tdata), .m_axis_tkeep(b_tkeep), .m_axis_tuser(b_tuser),
        .m_axis_tlast(b_tlast), .m_axis_tvalid(b_tvalid), .m_axis_tready(m_tready),
        .flush_pulse(b_flush));

    axis_burst_packetizer #(.MAX_BEATS(1), .TIMEOUT_CYCLES(8)) dut_c (
        .axis_clk(clk), .axis_rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
        .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid), .s_axis_tready(c_tready),
        .m_axis_tdata(c_tdata), .m_axis_tkeep(c_tkeep), .m_axis_tuser(c_tuser),
        .m_axis_tlast(c_tlast), .m_axis_tvalid(c_tvalid), .m_axis_tready(m_tready),
        .flush_pulse(c_flush));

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic [3:0]  u;
        logic        l;
        logic        f;
    } beat_t;

    typedef struct {
        logic [63:0] d;
        logic        lin;
        logic        el;
        logic        ef;
    } vec_t;

    beat_t in_q[$];
    beat_t out_q[$];
    int    a_flush_cnt = 0;
    int    rdy_bad = 0;
    int    b_out_cnt = 0;
    int    b_flush_cnt = 0;
    int    c_cnt = 0;
    int    c_bad = 0;
    logic  pend = 1'b0;

    int    ntot = 0;
    int    npass = 0;
    vec_t  vecs[18];

    // Observation at negedge: a valid&&ready seen here completes at the next posedge.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_flush) a_flush_cnt++;
            pend = pend | a_flush;
            if (a_tvalid && m_tready) begin
                out_q.push_back('{a_tdata, a_tkeep, a_tuser, a_tlast, pend});
                pend = 1'b0;
            end
            if (s_tvalid && a_tready)
                in_q.push_back('{s_tdata, s_tkeep, s_tuser, s_tlast, 1'b0});
            if (s_tvalid && !a_tready && !(a_tvalid && !m_tready)) rdy_bad++;
            if (b_tvalid && m_tready) b_out_cnt++;
            if (b_flush) b_flush_cnt++;
            if (c_tvalid && m_tready) begin
                c_cnt++;
                if (!c_tlast) c_bad++;
            end
        end else begin
            pend = 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_tready = rand_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] d, input logic [7:0] k, input logic [3:0] u, input logic l);
        logic hs;
        s_tdata = d;
        s_tkeep = k;
        s_tuser = u;
        s_tlast = l;
        s_tvalid = 1'b1;
        hs = 1'b0;
        for (int i = 0; i < 500 && !hs; i++) begin
            @(negedge clk);
            hs = sel ? b_tready : a_tready;
            @(posedge clk);
            #1;
        end
        if (!hs) chk("send_handshake", 0, 1);
    endtask

    task automatic wait_out(input int n, input int lim);
        for (int i = 0; i < lim && out_q.size() < n; i++) begin
            @(posedge clk);
            #1;
        end
        chk("wait_out_count", out_q.size() >= n, 1);
    endtask

    task automatic run_vecs(input int lo, input int n);
        int ob, fb;
        do_reset();
        ob = out_q.size();
        fb = a_flush_cnt;
        for (int i = 0; i < n; i++) send(vecs[lo+i].d, 8'hff, 4'(i), vecs[lo+i].lin);
        s_tvalid = 1'b0;
        wait_out(ob + n, 200);
        repeat (4) @(posedge clk);
        #1;
        chk("vec_out_total", out_q.size(), ob + n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("vec%0d_data", lo+i), out_q[ob+i].d, vecs[lo+i].d);
            chk($sformatf("vec%0d_last", lo+i), out_q[ob+i].l, vecs[lo+i].el);
            chk($sformatf("vec%0d_flush", lo+i), out_q[ob+i].f, vecs[lo+i].ef);
        end
        chk("vec_flush_total", a_flush_cnt - fb, 1);
    endtask

    task automatic latency(input logic l, input int exp_k, input logic exp_f);
        int k;
        logic got;
        do_reset();
        @(posedge clk);
        #1;
        s_tdata = 64'h5a5a; s_tkeep = 8'h0f; s_tuser = 4'h3; s_tlast = l; s_tvalid = 1'b1;
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        k = 1;
        got = 1'b0;
        while (k < 40 && !got) begin
            @(posedge clk);
            #1;
            k++;
            got = a_tvalid;
        end
        chk("latency_edges", k, exp_k);
        chk("latency_tlast", a_tlast, 1);
        chk("latency_flush", a_flush, exp_f);
        @(posedge clk);
        #1;
        chk("latency_flush_gone", a_flush, 0);
        chk("latency_valid_gone", a_tvalid, 0);
    endtask

    initial begin
        for (int i = 0; i < 10; i++)
            vecs[i] = '{64'(100 + i), 1'b0, (i == 3 || i == 7 || i == 9), (i == 9)};
        for (int i = 0; i < 8; i++)
            vecs[10+i] = '{64'(200 + i), (i == 1), (i == 1 || i == 5 || i == 7), (i == 7)};

        // Reset state
        s_tvalid = 1'b1;
        #12;
        chk("rst_m_tvalid", a_tvalid, 0);
        chk("rst_m_tlast", a_tlast, 0);
        chk("rst_flush", a_flush, 0);
        chk("rst_s_tready", a_tready, 0);
        s_tvalid = 1'b0;

        // Limit and timeout closing, then input-tlast closing
        run_vecs(0, 10);
        chk("c_beats_seen", c_cnt > 0, 1);
        chk("c_all_tlast", c_bad, 0);
        run_vecs(10, 8);

        // Idle timeout and tlast latency from the edge the beat is presented
        latency(1'b0, 10, 1'b1);
        latency(1'b1, 2, 1'b0);

        // Random traffic against packet-rule scoreboard
        begin
            int ib, ob, rb, plen;
            logic exp_f;
            do_reset();
            ib = in_q.size();
            ob = out_q.size();
            rb = rdy_bad;
            rand_mode = 1'b1;
            for (int i = 0; i < 1000; i++) begin
                send({$urandom, $urandom}, 8'($urandom), 4'($urandom), ($urandom_range(0, 4) == 0));
                if ($urandom_range(0, 7) == 0) begin
                    s_tvalid = 1'b0;
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
            end
            s_tvalid = 1'b0;
            wait_out(ob + 1000, 20000);
            rand_mode = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            chk("rand_in_count", in_q.size() - ib, 1000);
            chk("rand_out_count", out_q.size() - ob, 1000);
            chk("rand_ready_low_only_when_full", rdy_bad - rb, 0);
            plen = 0;
            for (int i = 0; i < 1000 && ob + i < out_q.size(); i++) begin
                plen++;
                chk($sformatf("rand%0d_payload", i),
                    {out_q[ob+i].d, out_q[ob+i].k, out_q[ob+i].u},
                    {in_q[ib+i].d, in_q[ib+i].k, in_q[ib+i].u});
                if (in_q[ib+i].l || plen == 4)
                    chk($sformatf("rand%0d_tlast", i), out_q[ob+i].l, 1);
                exp_f = out_q[ob+i].l && !in_q[ib+i].l && (plen != 4);
                chk($sformatf("rand%0d_flush", i), out_q[ob+i].f, exp_f);
                if (out_q[ob+i].l) plen = 0;
            end
        end

        // Timeout disabled: the last beat is held indefinitely
        begin
            int bo, bf;
            do_reset();
            sel = 1'b1;
            bo = b_out_cnt;
            bf = b_flush_cnt;
            for (int i = 0; i < 3; i++) send(64'(500 + i), 8'hff, 4'h0, 1'b0);
            s_tvalid = 1'b0;
            repeat (100) @(posedge clk);
            #1;
            sel = 1'b0;
            chk("notimeout_out_count", b_out_cnt - bo, 2);
            chk("notimeout_flush_count", b_flush_cnt - bf, 0);
            chk("notimeout_valid_idle", b_tvalid, 0);
        end

        // Reset in mid-packet, then a fresh packet of MAX_BEATS
        begin
            int ob;
            do_reset();
            for (int i = 0; i < 3; i++) send(64'(300 + i), 8'hff, 4'h1, 1'b0);
            rst = 1'b1;
            #1;
            chk("midrst_m_tvalid", a_tvalid, 0);
            chk("midrst_s_tready", a_tready, 0);
            s_tvalid = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
            ob = out_q.size();
            for (int i = 0; i < 4; i++) send(64'(400 + i), 8'hff, 4'h2, 1'b0);
            s_tvalid = 1'b0;
            wait_out(ob + 4, 200);
            repeat (12) @(posedge clk);
            #1;
            chk("midrst_out_total", out_q.size() - ob, 4);
            for (int i = 0; i < 4 && ob + i < out_q.size(); i++) begin
                chk($sformatf("midrst%0d_data", i), out_q[ob+i].d, 64'(400 + i));
                chk($sformatf("midrst%0d_last", i), out_q[ob+i].l, (i == 3));
            end
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
